// File: rtl/cache_rsp_checker_if.sv
// Response types and the response-bus interface for cache_rsp_checker.
// The interface carries the reference-model and DUT read responses.
package cache_rsp_pkg;
  localparam int ADDR_W = 32;
  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] address;
    logic [REG_W-1:0]  reg_id;
    logic [DATA_W-1:0] data;
  } t_rd_rsp;
endpackage

interface cache_rsp_if;
  import cache_rsp_pkg::*;

  // Valid-only streams: there is no ready. Each cycle with valid=1 is exactly
  // one response, and the checker must accept it in that same cycle.
  t_rd_rsp ref_rsp;
  t_rd_rsp dut_rsp;

  modport master (output ref_rsp, output dut_rsp);
  modport slave  (input  ref_rsp, input  dut_rsp);
endinterface

// File: rtl/cache_rsp_checker.sv
// In-order read-response checker: queues expected responses from the reference
// model and compares each DUT response against the oldest queued entry.
module cache_rsp_checker
  import cache_rsp_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  cache_rsp_if.slave             rsp,
  output logic [$clog2(DEPTH):0] pending,
  output logic [CNT_W-1:0]       match_cnt,
  output logic [CNT_W-1:0]       mismatch_cnt,
  output logic                   err_pulse,
  output logic                   err_sticky,
  output logic                   unexp_sticky,
  output logic                   ovf_sticky,
  output logic                   tmo_sticky
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int PAY_W = ADDR_W + REG_W + DATA_W;
  localparam int AGE_W = $clog2(TIMEOUT + 1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(TIMEOUT);
  localparam logic [AGE_W-1:0] AGE_PRE  = AGE_W'(TIMEOUT - 1);

  logic [PAY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [AGE_W-1:0] age;

  logic             empty;
  logic             full;
  logic             push;
  logic             dut_v;
  logic             bypass;
  logic             unexp_ev;
  logic             pop_fifo;
  logic             push_acc;
  logic             ovf_ev;
  logic             tmo_ev;
  logic             cmp_v;
  logic             mism_ev;
  logic             match_ev;
  logic             err_ev;
  logic [PAY_W-1:0] ref_pay;
  logic [PAY_W-1:0] dut_pay;
  logic [PAY_W-1:0] exp_pay;
  logic [PTR_W:0]   pending_next;
  logic [AGE_W-1:0] age_next;

  assign ref_pay = {rsp.ref_rsp.address, rsp.ref_rsp.reg_id, rsp.ref_rsp.data};
  assign dut_pay = {rsp.dut_rsp.address, rsp.dut_rsp.reg_id, rsp.dut_rsp.data};

  always_comb begin
    empty    = (pending == '0);
    full     = (pending == FULL_CNT);
    push     = rsp.ref_rsp.valid;
    dut_v    = rsp.dut_rsp.valid;
    // An empty queue with both responses present compares them directly.
    bypass   = empty && push && dut_v;
    unexp_ev = empty && !push && dut_v;
    pop_fifo = !empty && dut_v;
    // A pop frees the slot this cycle, so a full queue still accepts the push.
    push_acc = push && !bypass && (!full || pop_fifo);
    ovf_ev   = push && full && !pop_fifo;
    exp_pay  = bypass ? ref_pay : mem[rd_ptr];
    cmp_v    = bypass || pop_fifo;
    match_ev = cmp_v && (exp_pay == dut_pay);
    mism_ev  = cmp_v && (exp_pay != dut_pay);

    pending_next = pending;
    case ({push_acc, pop_fifo})
      2'b10:   pending_next = pending + 1'b1;
      2'b01:   pending_next = pending - 1'b1;
      default: pending_next = pending;
    endcase

    age_next = age;
    tmo_ev   = 1'b0;
    if (pop_fifo || empty) begin
      age_next = '0;
    end else if (age != AGE_MAX) begin
      age_next = age + 1'b1;
      tmo_ev   = (age == AGE_PRE);
    end

    err_ev = mism_ev || unexp_ev || ovf_ev || tmo_ev;
  end

  // Queue storage carries no reset; pending alone defines which slots are live.
  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr] <= ref_pay;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      pending      <= '0;
      age          <= '0;
      match_cnt    <= '0;
      mismatch_cnt <= '0;
      err_pulse    <= 1'b0;
      err_sticky   <= 1'b0;
      unexp_sticky <= 1'b0;
      ovf_sticky   <= 1'b0;
      tmo_sticky   <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop_fifo) rd_ptr <= rd_ptr + 1'b1;
      pending <= pending_next;
      age     <= age_next;
      if (match_ev && (match_cnt != '1)) match_cnt <= match_cnt + 1'b1;
      if ((mism_ev || unexp_ev) && (mismatch_cnt != '1)) mismatch_cnt <= mismatch_cnt + 1'b1;
      err_pulse    <= err_ev;
      err_sticky   <= err_sticky   | err_ev;
      unexp_sticky <= unexp_sticky | unexp_ev;
      ovf_sticky   <= ovf_sticky   | ovf_ev;
      tmo_sticky   <= tmo_sticky   | tmo_ev;
    end
  end
endmodule

// File: tb/tb_cache_rsp_checker.sv
// Directed bench for cache_rsp_checker (DEPTH=16, TIMEOUT=8, CNT_W=32) with
// hand-computed expectations checked by immediate assertions.
module tb_cache_rsp_checker;
  import cache_rsp_pkg::*;

  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 32;

  logic                   clk;
  logic                   rst_n;
  logic [$clog2(DEPTH):0] pending;
  logic [CNT_W-1:0]       match_cnt;
  logic [CNT_W-1:0]       mismatch_cnt;
  logic                   err_pulse;
  logic                   err_sticky;
  logic                   unexp_sticky;
  logic                   ovf_sticky;
  logic                   tmo_sticky;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int pulses;

  cache_rsp_if rsp ();

  cache_rsp_checker #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rsp          (rsp.slave),
    .pending      (pending),
    .match_cnt    (match_cnt),
    .mismatch_cnt (mismatch_cnt),
    .err_pulse    (err_pulse),
    .err_sticky   (err_sticky),
    .unexp_sticky (unexp_sticky),
    .ovf_sticky   (ovf_sticky),
    .tmo_sticky   (tmo_sticky)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Driver helpers
  function automatic t_rd_rsp mk(input logic [31:0] a, input logic [4:0] r, input logic [31:0] d);
    t_rd_rsp t;
    t.valid   = 1'b1;
    t.address = a;
    t.reg_id  = r;
    t.data    = d;
    return t;
  endfunction

  task automatic step(input t_rd_rsp r, input t_rd_rsp d);
    @(negedge clk);
    rsp.ref_rsp = r;
    rsp.dut_rsp = d;
    @(posedge clk);
    #1;
    rsp.ref_rsp = '0;
    rsp.dut_rsp = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    rsp.ref_rsp = '0;
    rsp.dut_rsp = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    rsp.ref_rsp = '0;
    rsp.dut_rsp = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_match", 64'(match_cnt), 64'd0);
    chk("rst_mismatch", 64'(mismatch_cnt), 64'd0);
    chk("rst_err_pulse", 64'(err_pulse), 64'd0);
    chk("rst_stickies", 64'({err_sticky, unexp_sticky, ovf_sticky, tmo_sticky}), 64'd0);

    // Test 1: ref rsp, DUT identical rsp four cycles later
    idle(2);
    step(mk(32'h10, 5'd5, 32'hDEADBEEF), '0);
    chk("t1_pending_after_push", 64'(pending), 64'd1);
    idle(3);
    step('0, mk(32'h10, 5'd5, 32'hDEADBEEF));
    chk("t1_match", 64'(match_cnt), 64'd1);
    chk("t1_pending", 64'(pending), 64'd0);
    chk("t1_err_pulse", 64'(err_pulse), 64'd0);
    chk("t1_err_sticky", 64'(err_sticky), 64'd0);

    // Test 2: data differs by one bit
    step(mk(32'h20, 5'd3, 32'h12345678), '0);
    step('0, mk(32'h20, 5'd3, 32'h12345679));
    chk("t2_mismatch", 64'(mismatch_cnt), 64'd1);
    chk("t2_match_unchanged", 64'(match_cnt), 64'd1);
    chk("t2_err_pulse_high", 64'(err_pulse), 64'd1);
    chk("t2_err_sticky", 64'(err_sticky), 64'd1);
    chk("t2_unexp_clear", 64'(unexp_sticky), 64'd0);
    idle(1);
    chk("t2_err_pulse_low", 64'(err_pulse), 64'd0);

    // Test 3: DUT rsp with nothing expected
    do_reset();
    step('0, mk(32'h30, 5'd1, 32'hCAFE0001));
    chk("t3_unexp", 64'(unexp_sticky), 64'd1);
    chk("t3_mismatch", 64'(mismatch_cnt), 64'd1);
    chk("t3_pending", 64'(pending), 64'd0);
    chk("t3_err_pulse", 64'(err_pulse), 64'd1);

    // Test 4: fill to DEPTH, overflow on the 17th, then drain
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(mk(32'(i * 4), 5'(i), 32'(32'hA000 + i)), '0);
    chk("t4_pending_full", 64'(pending), 64'd16);
    chk("t4_no_ovf_yet", 64'(ovf_sticky), 64'd0);
    step(mk(32'h999, 5'd31, 32'hBAD), '0);
    chk("t4_ovf", 64'(ovf_sticky), 64'd1);
    chk("t4_pending_stays", 64'(pending), 64'd16);
    chk("t4_ovf_pulse", 64'(err_pulse), 64'd1);
    // Full queue: push and pop together is legal
    step(mk(32'(16 * 4), 5'(16), 32'(32'hA000 + 16)), mk(32'h0, 5'd0, 32'hA000));
    chk("t4_full_pushpop_pending", 64'(pending), 64'd16);
    chk("t4_full_pushpop_no_err", 64'(err_pulse), 64'd0);
    for (int i = 1; i <= DEPTH; i++) step('0, mk(32'(i * 4), 5'(i), 32'(32'hA000 + i)));
    chk("t4_match", 64'(match_cnt), 64'd17);
    chk("t4_mismatch", 64'(mismatch_cnt), 64'd0);
    chk("t4_pending_empty", 64'(pending), 64'd0);

    // Test 5: head waits past TIMEOUT
    do_reset();
    step(mk(32'h50, 5'd7, 32'h5555AAAA), '0);
    idle(7);
    chk("t5_tmo_not_yet", 64'(tmo_sticky), 64'd0);
    idle(1);
    chk("t5_tmo", 64'(tmo_sticky), 64'd1);
    chk("t5_tmo_pulse", 64'(err_pulse), 64'd1);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      idle(1);
      if (err_pulse) pulses++;
    end
    chk("t5_single_pulse", 64'(pulses), 64'd0);
    step('0, mk(32'h50, 5'd7, 32'h5555AAAA));
    chk("t5_late_match", 64'(match_cnt), 64'd1);
    chk("t5_pending", 64'(pending), 64'd0);
    chk("t5_no_mismatch", 64'(mismatch_cnt), 64'd0);

    // Test 6: bypass on empty queue, then reset with entries in flight
    do_reset();
    step(mk(32'h60, 5'd2, 32'h0BADF00D), mk(32'h60, 5'd2, 32'h0BADF00D));
    chk("t6_bypass_match", 64'(match_cnt), 64'd1);
    chk("t6_bypass_pending", 64'(pending), 64'd0);
    chk("t6_bypass_no_err", 64'(err_sticky), 64'd0);
    step(mk(32'h64, 5'd2, 32'h11111111), mk(32'h64, 5'd9, 32'h11111111));
    chk("t6_bypass_mismatch", 64'(mismatch_cnt), 64'd1);
    chk("t6_bypass_not_unexp", 64'(unexp_sticky), 64'd0);
    for (int i = 0; i < 3; i++) step(mk(32'(32'h70 + i), 5'(i), 32'(i)), '0);
    chk("t6_pending3", 64'(pending), 64'd3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_pending", 64'(pending), 64'd0);
    chk("t6_rst_match", 64'(match_cnt), 64'd0);
    chk("t6_rst_mismatch", 64'(mismatch_cnt), 64'd0);
    chk("t6_rst_sticky", 64'(err_sticky), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // Stale entries must be gone: a DUT rsp is now unexpected
    step('0, mk(32'h70, 5'd0, 32'd0));
    chk("t6_after_rst_unexp", 64'(unexp_sticky), 64'd1);
    chk("t6_after_rst_match", 64'(match_cnt), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
